// File: rtl/mux_rr_n.sv
// N-channel registered multiplexer with valid/ready handshakes and round-robin arbitration.
// Optional build macro MUX_RR_FORCE_EN adds force_en/force_sel to pin the grant to one channel.
module mux_rr_n #(
    parameter int NCH = 4,
    parameter int W   = 8,
    parameter int SW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*W-1:0]  in_data,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready
`ifdef MUX_RR_FORCE_EN
    ,
    input  logic              force_en,
    input  logic [SW-1:0]     force_sel
`endif
);

    logic [W-1:0]  ch_data [NCH];
    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] last_q, last_d;

    logic          rr_valid;
    logic [SW-1:0] rr_idx;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;
    logic          upd_last;
    logic          load;
    logic          xfer;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*W +: W];
            // Reset gating keeps producers from seeing a handshake while rst_n is low.
            assign in_ready[gi] = rst_n & xfer & (grant_idx == SW'(gi));
        end
    endgenerate

    // Search from last+1 with wrap; iterating farthest-first lets the nearest requester win.
    always_comb begin
        rr_valid = 1'b0;
        rr_idx   = '0;
        for (int k = NCH; k >= 1; k--) begin
            if (in_valid[SW'((int'(last_q) + k) % NCH)]) begin
                rr_valid = 1'b1;
                rr_idx   = SW'((int'(last_q) + k) % NCH);
            end
        end
    end

`ifdef MUX_RR_FORCE_EN
    always_comb begin
        grant_valid = rr_valid;
        grant_idx   = rr_idx;
        upd_last    = 1'b1;
        if (force_en) begin
            grant_valid = ({1'b0, force_sel} < (SW+1)'(NCH)) && in_valid[force_sel];
            grant_idx   = force_sel;
            upd_last    = 1'b0;
        end
    end
`else
    assign grant_valid = rr_valid;
    assign grant_idx   = rr_idx;
    assign upd_last    = 1'b1;
`endif

    assign load = !out_valid_q || out_ready;
    assign xfer = load && grant_valid;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        last_d      = last_q;
        if (load) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_data_d = ch_data[grant_idx];
                out_ch_d   = grant_idx;
                if (upd_last) begin
                    last_d = grant_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last_q      <= SW'(NCH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n (NCH=4, W=8): reset, rotation, wrap, back-pressure, idle, force.
module tb_mux_rr_n;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int SW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NCH*W-1:0]  in_data;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_ch;
    logic              out_valid;
    logic              out_ready;
`ifdef MUX_RR_FORCE_EN
    logic              force_en;
    logic [SW-1:0]     force_sel;
`endif

    int errors = 0;
    int checks = 0;

    mux_rr_n #(.NCH(NCH), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_RR_FORCE_EN
        ,
        .force_en  (force_en),
        .force_sel (force_sel)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic [1:0] ch);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
        chk({tag, "_ch"}, {30'd0, out_ch}, {30'd0, ch});
        $display("xfer %s: out_ch=%0d out_data=%02h", tag, out_ch, out_data);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 32'h44332211;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
`ifdef MUX_RR_FORCE_EN
        force_en  = 1'b0;
        force_sel = 2'd0;
`endif
        tick();
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_ch", {30'd0, out_ch}, 32'd0);
        chk("rst_ready", {28'd0, in_ready}, 32'd0);

        // Fair rotation starting from channel 0.
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rot_ready0", {28'd0, in_ready}, 32'b0001);
        tick(); chk_out("rot0", 8'h11, 2'd0);
        chk("rot_ready1", {28'd0, in_ready}, 32'b0010);
        tick(); chk_out("rot1", 8'h22, 2'd1);
        tick(); chk_out("rot2", 8'h33, 2'd2);
        tick(); chk_out("rot3", 8'h44, 2'd3);
        tick(); chk_out("rot4", 8'h11, 2'd0);

        // Sparse requests with wrap from last=3.
        in_valid = 4'b1000;
        tick(); chk_out("sp_set3", 8'h44, 2'd3);
        in_valid = 4'b1010;
        tick(); chk_out("sp_a", 8'h22, 2'd1);
        tick(); chk_out("sp_b", 8'h44, 2'd3);
        tick(); chk_out("sp_c", 8'h22, 2'd1);
        tick(); chk_out("sp_d", 8'h44, 2'd3);
        in_valid = 4'b1000;
        tick(); chk_out("sp_only3a", 8'h44, 2'd3);
        tick(); chk_out("sp_only3b", 8'h44, 2'd3);

        // Back-pressure holding ch2 = A5.
        in_data  = 32'h44A52211;
        in_valid = 4'b0100;
        tick(); chk_out("bp_load", 8'hA5, 2'd2);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", {28'd0, in_ready}, 32'd0);
            tick(); chk_out("bp_hold", 8'hA5, 2'd2);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'd0, in_ready}, 32'b1000);
        tick(); chk_out("bp_next", 8'h44, 2'd3);

        // Idle: valid drops, data holds.
        in_valid = 4'b0000;
        tick();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_data", {24'd0, out_data}, 32'h44);
        chk("idle_ch", {30'd0, out_ch}, 32'd3);
        tick();
        chk("idle_valid2", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream with a pending word.
        in_valid = 4'b0010;
        tick(); chk_out("pre_rst", 8'h22, 2'd1);
        in_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ch", {30'd0, out_ch}, 32'd0);
        chk("mid_rst_ready", {28'd0, in_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {28'd0, in_ready}, 32'b0001);
        tick(); chk_out("post_rst", 8'h11, 2'd0);

`ifdef MUX_RR_FORCE_EN
        force_en  = 1'b1;
        force_sel = 2'd2;
        tick(); chk_out("force_a", 8'hA5, 2'd2);
        tick(); chk_out("force_b", 8'hA5, 2'd2);
        in_valid = 4'b1011;
        #1;
        chk("force_novalid_ready", {28'd0, in_ready}, 32'd0);
        tick();
        chk("force_novalid_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 4'b1111;
        force_en = 1'b0;
        tick(); chk_out("force_resume", 8'h22, 2'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes and round-robin channel selection. It is the next generation of the team's combinational 4:1 select mux. The select lines are replaced by an internal fair arbiter, and the output is registered with a valid/ready interface. It sits between several data producers (sensor, UART RX, test-pattern sources) and one shared consumer.

## Interface
- NCH, default 4: number of input channels, legal 2..16.
- W, default 8: data width per channel, legal 1..64.
- SW, default $clog2(NCH): derived select/channel-index width; not overridden.
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk externally.
- in_data  input  NCH*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  NCH  channel i presents a word.
- in_ready  output  NCH  channel i word accepted this cycle; at most one bit set.
- out_data  output  W  registered selected word.
- out_ch  output  SW  index of the channel that produced out_data.
- out_valid  output  1  out_data/out_ch hold a word.
- out_ready  input  1  consumer accepts the word this cycle.
- force_en, force_sel  input  1, SW  present only with MUX_RR_FORCE_EN (see Configuration).

## Operation
- Output stage: one register holding out_data, out_ch and out_valid.
- Load condition: load = !out_valid | out_ready.
- Arbitration: the grant goes to the first channel with in_valid=1, searched from (last+1) mod NCH upward with wrap.
  - last is the index of the most recent granted channel.
  - There is no grant if all in_valid are 0.
- in_ready[g] = load & grant[g]; all other in_ready bits are 0.
- in_ready may depend combinationally on in_valid and out_ready.
- On an edge with a transfer (load & any in_valid):
  - out_data ← in_data[g].
  - out_ch ← g.
  - out_valid ← 1.
  - last ← g.
- On an edge with load and no in_valid: out_valid ← 0; out_data, out_ch and last hold.
- With !load, the output registers and last hold; a stalled output stays stable until accepted.
- Fairness: with all NCH channels continuously valid and out_ready=1, grants cycle 0,1,…,NCH-1,0,… Any requesting channel waits at most NCH-1 grants.
- Producers must hold in_data and in_valid until in_ready; a channel may drop in_valid before grant, and the arbiter then skips it.
- Reset values (async, rst_n=0):
  - out_valid=0, out_data=0, out_ch=0.
  - last=NCH-1, so channel 0 has first priority after reset.
  - in_ready=0 while rst_n=0.
- Reset mid-transfer: a pending output word is discarded, with no handshake completed. The bench must not count it.

## Timing
- Latency: 1 cycle from in_valid&in_ready edge to out_valid=1 with that word.
- Throughput: 1 word/cycle sustained when out_ready=1.
- Back-pressure: with out_valid=1 and out_ready=0, all in_ready=0 in that cycle.
- Simultaneous out_ready=1 and a new grant: the old word is consumed and the new word is loaded on the same edge, with no bubble.
- Boundary cases:
  - Wrap from last=NCH-1 searches channel 0 first.
  - With a single requesting channel, that channel is granted every cycle regardless of last.
- No combinational path from in_data to any output; out_* are register outputs only.

## Configuration
- MUX_RR_FORCE_EN defined:
  - Adds the force_en and force_sel ports.
  - With force_en=1, arbitration is bypassed: grant = force_sel if in_valid[force_sel]=1, else no grant.
  - last is not updated while forced.
  - A force_sel ≥ NCH yields no grant.
- MUX_RR_FORCE_EN undefined: the ports do not exist; pure round-robin only.

## Test plan
- Reset: assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, out_ch=0, in_ready=0 immediately. After release, all channels valid → first grant is channel 0.
- Fair rotation: NCH=4, W=8, in_data={8'h44,8'h33,8'h22,8'h11}, all valid, out_ready=1.
  - Required out_data per cycle: 11,22,33,44,11.
  - Required out_ch per cycle: 0,1,2,3,0.
- Sparse/wrap: only ch1 and ch3 valid, last=3 → grants 1,3,1,3. Then ch1 drops → ch3 is granted every cycle.
- Back-pressure: out_ready=0 for 5 cycles with ch2=8'hA5 loaded.
  - out_data stays A5 and out_valid=1; in_ready=0 throughout.
  - out_ready=1 → next word is loaded on the same edge.
- Idle: all in_valid=0 with out_ready=1 → out_valid drops to 0 after one cycle; out_data holds its last value.
- Force (MUX_RR_FORCE_EN): force_en=1, force_sel=2, all valid → ch2 is granted every cycle.
  - force_sel=5 → no grant.
  - Release force → rotation resumes from last before force.
